// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a registered-output ROM and buffers returned words in a small in-order FIFO.
// Define FETCH_SKID_BUF_EN for a 2-entry buffer (one instruction per cycle); default is 1 entry (one every 2 cycles).
module fetch_unit #(
  parameter logic [10:0] RESET_PC = 11'h000
) (
  input  logic        clk,
  input  logic        resetb,
  output logic [10:0] rom_addr,
  input  logic [31:0] rom_data,
  input  logic        redirect,
  input  logic [10:0] redirect_addr,
  output logic [31:0] instr,
  output logic [10:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

`ifdef FETCH_SKID_BUF_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif
  localparam int CW = $clog2(D + 2);

  typedef struct packed {
    logic [31:0] instr;
    logic [10:0] pc;
  } entry_t;

  // Handshake: a word transfers on any cycle with instr_valid & instr_ready,
  // except a redirect cycle, where the handshake is void and the buffer is flushed.

  logic [10:0]   r_pc;
  logic [10:0]   r_reqpc;
  logic          r_req;
  logic [CW-1:0] r_count;
  entry_t        r_buf [D];

  entry_t        w_buf_nxt [D];
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_wr_idx;
  logic [CW:0]   w_occ;
  logic          w_pop;
  logic          w_push;
  logic          w_issue;

  assign rom_addr    = r_pc;
  assign instr_valid = (r_count != '0);
  assign instr       = r_buf[0].instr;
  assign instr_pc    = r_buf[0].pc;

  assign w_pop  = instr_valid & instr_ready & ~redirect;
  assign w_push = r_req & ~redirect;

  // Slots committed next cycle: buffered + in flight - leaving now; a new fetch needs a free one.
  assign w_occ   = {1'b0, r_count} + {{CW{1'b0}}, r_req} - {{CW{1'b0}}, instr_valid & instr_ready};
  assign w_issue = ~redirect & (w_occ < (CW+1)'(D));

  assign w_wr_idx = r_count - {{(CW-1){1'b0}}, w_pop};

  always_comb begin
    w_buf_nxt   = r_buf;
    w_count_nxt = r_count;
    if (redirect) begin
      w_count_nxt = '0;
    end else begin
      if (w_pop) begin
        for (int i = 0; i < D - 1; i++) begin
          w_buf_nxt[i] = r_buf[i + 1];
        end
      end
      if (w_push) begin
        for (int i = 0; i < D; i++) begin
          if (w_wr_idx == CW'(i)) begin
            w_buf_nxt[i] = '{instr: rom_data, pc: r_reqpc};
          end
        end
      end
      w_count_nxt = r_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_reqpc <= 11'h000;
      r_count <= '0;
      for (int i = 0; i < D; i++) begin
        r_buf[i] <= '0;
      end
    end else begin
      r_count <= w_count_nxt;
      r_buf   <= w_buf_nxt;
      if (redirect) begin
        r_pc  <= redirect_addr;
        r_req <= 1'b0;
      end else if (w_issue) begin
        r_req   <= 1'b1;
        r_reqpc <= r_pc;
        r_pc    <= r_pc + 11'd1;
      end else begin
        r_req <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: ROM model mem[i]=i, directed phases, scoreboard of expected fetch addresses.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        resetb;
  logic [10:0] rom_addr;
  logic [31:0] rom_data = 32'h0;
  logic        redirect;
  logic [10:0] redirect_addr;
  logic [31:0] instr;
  logic [10:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  logic [10:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  int x0;

`ifdef FETCH_SKID_BUF_EN
  localparam int STREAM_20 = 20;
  localparam int RST_10    = 8;
`else
  localparam int STREAM_20 = 10;
  localparam int RST_10    = 4;
`endif

  fetch_unit #(.RESET_PC(11'h000)) dut (
    .clk(clk), .resetb(resetb), .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect(redirect), .redirect_addr(redirect_addr), .instr(instr),
    .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );

  // clock / ROM model (registered address, mem[i] = i)
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= {21'h0, rom_addr};

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic load_exp(input logic [10:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 11'(i));
  endtask

  task automatic do_redirect(input logic [10:0] addr);
    redirect      = 1'b1;
    redirect_addr = addr;
    exp_q.delete();
    next_cycle();
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (resetb && instr_valid && instr_ready && !redirect) begin
      xfers++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected", {21'h0, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        check("sb_pc", {21'h0, instr_pc}, {21'h0, e});
        check("sb_instr", instr, {21'h0, e});
      end
    end
  end

  initial begin
    resetb = 1'b0; redirect = 1'b0; redirect_addr = 11'h0; instr_ready = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_rom_addr", {21'h0, rom_addr}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", {21'h0, instr_pc}, 32'h0);

    // release: first issue now, valid two cycles later
    next_cycle();
    resetb = 1'b1;
    load_exp(11'h000, 64);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("lat_valid", {31'h0, instr_valid}, (c == 2) ? 32'h1 : 32'h0);
    end
    check("lat_instr_pc", {21'h0, instr_pc}, 32'h0);
    check("lat_instr", instr, 32'h0);

    // streaming throughput over 20 cycles
    next_cycle();
    instr_ready = 1'b1;
    x0 = xfers;
    repeat (20) next_cycle();
    check("stream_xfers", 32'(xfers - x0), 32'(STREAM_20));

    // backpressure: head must hold the next expected word
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 1) begin
        check("bp_valid", {31'h0, instr_valid}, 32'h1);
        check("bp_pc", {21'h0, instr_pc}, (exp_q.size() > 0) ? {21'h0, exp_q[0]} : 32'hFFFF_FFFF);
        check("bp_instr", instr, (exp_q.size() > 0) ? {21'h0, exp_q[0]} : 32'hFFFF_FFFF);
      end
      next_cycle();
    end
    instr_ready = 1'b1;
    repeat (6) next_cycle();

    // fill the buffer, then two back-to-back redirects; the last one wins
    instr_ready = 1'b0;
    repeat (3) next_cycle();
    instr_ready = 1'b1;
    do_redirect(11'h055);
    do_redirect(11'h100);
    redirect = 1'b0;
    load_exp(11'h100, 40);
    x0 = xfers;
    @(negedge clk);
    check("redir_rom_addr", {21'h0, rom_addr}, 32'h100);
    check("redir_valid0", {31'h0, instr_valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("redir_valid1", {31'h0, instr_valid}, 32'h0);
    next_cycle();
    @(negedge clk);
    check("redir_valid2", {31'h0, instr_valid}, 32'h1);
    check("redir_pc", {21'h0, instr_pc}, 32'h100);
    repeat (10) next_cycle();
    check("redir_progress", {31'h0, (xfers - x0) >= 4}, 32'h1);

    // address wrap 7FE -> 001
    do_redirect(11'h7FE);
    redirect = 1'b0;
    exp_q.push_back(11'h7FE); exp_q.push_back(11'h7FF);
    exp_q.push_back(11'h000); exp_q.push_back(11'h001);
    exp_q.push_back(11'h002); exp_q.push_back(11'h003);
    exp_q.push_back(11'h004); exp_q.push_back(11'h005);
    exp_q.push_back(11'h006); exp_q.push_back(11'h007);
    x0 = xfers;
    repeat (12) next_cycle();
    check("wrap_progress", {31'h0, (xfers - x0) >= 4}, 32'h1);

    // reset mid-operation with redirect held (ignored)
    instr_ready = 1'b0;
    repeat (3) next_cycle();
    resetb = 1'b0;
    redirect = 1'b1;
    redirect_addr = 11'h3AB;
    exp_q.delete();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("mrst_valid", {31'h0, instr_valid}, 32'h0);
    check("mrst_rom_addr", {21'h0, rom_addr}, 32'h0);
    check("mrst_instr", instr, 32'h0);
    check("mrst_instr_pc", {21'h0, instr_pc}, 32'h0);
    next_cycle();
    resetb = 1'b1;
    redirect = 1'b0;
    instr_ready = 1'b1;
    load_exp(11'h000, 40);
    x0 = xfers;
    repeat (10) next_cycle();
    check("mrst_xfers", 32'(xfers - x0), 32'(RST_10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 11'h000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetb  input  1  synchronous, active-low reset.
REQ-004 rom_addr  output  11  fetch address to the 2048x32 instruction ROM; the ROM registers it, so data returns in the next cycle.
REQ-005 rom_data  input  32  ROM read data for the address presented in the previous cycle.
REQ-006 redirect  input  1  flush and restart fetch (branch/jump).
REQ-007 redirect_addr  input  11  new fetch address, sampled when redirect=1.
REQ-008 instr  output  32  instruction at the buffer head.
REQ-009 instr_pc  output  11  address of instr.
REQ-010 instr_valid  output  1  buffer head holds a valid instruction.
REQ-011 instr_ready  input  1  consumer accepts the head; transfer when instr_valid & instr_ready.

Function
REQ-012 State: pc (11b), in-flight flag req_q, in-flight address reqpc_q, FIFO buffer of {instr, pc} entries, depth D (see Configuration).
REQ-013 rom_addr shall equal pc combinationally every cycle.
REQ-014 Issue in a cycle iff redirect=0 and (count + req_q - pop) < D, where pop = instr_valid & instr_ready.
REQ-015 On issue: req_q<=1, reqpc_q<=pc, pc<=pc+1 modulo 2048 (11'h7FF wraps to 11'h000); otherwise req_q<=0 and pc holds.
REQ-016 When req_q=1 and redirect=0, rom_data and reqpc_q shall be written to the buffer tail at the end of that cycle.
REQ-017 Push and pop in the same cycle shall both take effect; count unchanged.
REQ-018 Buffer shall never overflow; issue rule guarantees a slot for every in-flight fetch.
REQ-019 instr_valid = (count != 0); instr/instr_pc come from registered buffer head only; no combinational path rom_data -> instr.
REQ-020 Buffer holds order: instructions delivered in fetch order, no drops, no duplicates, while redirect=0.
REQ-021 Redirect (highest priority): buffer cleared, in-flight fetch discarded (req_q<=0, no push), pc<=redirect_addr, no issue that cycle; any handshake in that cycle is void; fetch resumes next cycle.
REQ-022 Redirect asserted on consecutive cycles: last redirect_addr wins.
REQ-023 Latency: instruction at address A issued in cycle N is instr_valid from cycle N+2 (issue N, capture end of N+1).
REQ-024 instr held stable while instr_valid=1 and instr_ready=0.

Reset
REQ-025 When resetb=0 at a rising edge: pc<=RESET_PC, req_q<=0, reqpc_q<=0, count<=0, buffer head data <=0.
REQ-026 Reset values: instr_valid=0, instr=32'h0, instr_pc=11'h0, rom_addr=RESET_PC.
REQ-027 Reset mid-operation discards buffered and in-flight fetches; redirect ignored while resetb=0.
REQ-028 First issue occurs in the first cycle with resetb=1; first instr_valid two cycles later.

Configuration
REQ-029 Macro FETCH_SKID_BUF_EN defined: D=2; with instr_ready held 1, one instruction per cycle sustained.
REQ-030 Macro FETCH_SKID_BUF_EN undefined: D=1; with instr_ready held 1, one instruction every 2 cycles; all other behaviour identical.

Verification
REQ-031 Reset: resetb=0 two cycles, RESET_PC=0 -> instr_valid=0, rom_addr=0; after release instr_valid=1 exactly 2 cycles later with instr=mem[0], instr_pc=0.
REQ-032 Streaming (EN defined), instr_ready=1, ROM mem[i]=i -> instr_pc 0,1,2,...,9 on 10 consecutive cycles, instr=instr_pc.
REQ-033 Backpressure: instr_ready=0 for 5 cycles mid-stream -> instr stable, count<=D, no pc skipped or repeated after ready returns.
REQ-034 Redirect to 11'h100 while buffer full and fetch in flight -> next instr_valid shows instr_pc=11'h100, stale entries never delivered.
REQ-035 Wrap: redirect to 11'h7FE, ready=1 -> instr_pc sequence 7FE,7FF,000,001.
REQ-036 FETCH_SKID_BUF_EN undefined, ready=1 for 20 cycles -> exactly 10 transfers, pc sequence contiguous.
